distance_qualifier: RTL

//  Sits between the ultrasonic ranger and the wheel-deploy controller.
//  - Smooths raw echo-width counts with a moving average.
//  - Applies hysteresis and N-sample confirmation to produce a clean deploy/retract decision.
//  - Fail-safe: forces deploy when the ranger goes silent.
//  Its deploy output drives the servo angle select, the LCD state and the LED.

---
 rtl/distance_qualifier_if.sv | 20 ++
 rtl/distance_qualifier.sv | 131 +++++++++++++
 2 files changed

// File: rtl/distance_qualifier_if.sv
// Ranger-side sample stream and deploy-decision outputs of the distance qualifier.
interface distance_qualifier_if;
  logic [19:0] distance_raw;
  logic        dist_valid;
  logic        deploy;
  logic [19:0] dist_avg;
  logic        avg_valid;
  logic        fault;
  logic [1:0]  state_dbg;

  modport master (
    output distance_raw, dist_valid,
    input  deploy, dist_avg, avg_valid, fault, state_dbg
  );

  modport slave (
    input  distance_raw, dist_valid,
    output deploy, dist_avg, avg_valid, fault, state_dbg
  );
endinterface

// File: rtl/distance_qualifier.sv
// Moving-average filter on ranger echo counts, hysteresis plus N-sample
// confirmation for the wheel deploy decision, and a stale-ranger fail-safe.
module distance_qualifier #(
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DEPLOY_TH  = 58000,
  parameter int unsigned RETRACT_TH = 72500,
  parameter int unsigned CONFIRM    = 3,
  parameter int unsigned STALE_CYC  = 6000000
) (
  input  logic                clk,
  input  logic                rst,
  distance_qualifier_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SW    = 20 + AVG_LOG2;
  localparam int unsigned FW    = AVG_LOG2 + 1;
  localparam int unsigned TW    = $clog2(STALE_CYC + 1);

  localparam logic [19:0]   DEP_TH     = 20'(DEPLOY_TH);
  localparam logic [19:0]   RET_TH     = 20'(RETRACT_TH);
  localparam logic [3:0]    CONF_LAST  = 4'(CONFIRM - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_LAST  = FW'(DEPTH - 1);
  localparam logic [TW-1:0] STALE_MAX  = TW'(STALE_CYC);
  localparam logic [TW-1:0] STALE_PRE  = TW'(STALE_CYC - 1);

  typedef enum logic [1:0] {
    S_FILL      = 2'b00,
    S_RETRACTED = 2'b01,
    S_DEPLOYED  = 2'b10,
    S_FAULT     = 2'b11
  } state_t;

  state_t        r_state;
  logic [19:0]   r_buf [DEPTH];
  logic [SW-1:0] r_sum;
  logic [FW-1:0] r_fill;
  logic [3:0]    r_confirm;
  logic [TW-1:0] r_stale;
  logic          r_deploy;
  logic          r_fault;
  logic          r_avg_valid;
  logic [19:0]   r_avg;

  logic [SW-1:0] w_sum_next;
  logic          w_full_now;
  logic          w_timeout;
  logic          w_qual;
  logic          w_decide;

  assign w_sum_next = r_sum + SW'(bus.distance_raw) - SW'(r_buf[DEPTH-1]);
  assign w_full_now = (r_fill >= FILL_LAST);
  // A sample arriving on the timeout cycle keeps the ranger alive.
  assign w_timeout  = (r_stale == STALE_PRE) && !bus.dist_valid && (r_state != S_FAULT);
  assign w_qual     = (r_state == S_RETRACTED) ? (r_avg < DEP_TH) : (r_avg > RET_TH);
  assign w_decide   = r_avg_valid && ((r_state == S_RETRACTED) || (r_state == S_DEPLOYED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_deploy    <= 1'b0;
      r_fault     <= 1'b0;
      r_avg_valid <= 1'b0;
      r_avg       <= '0;
      r_sum       <= '0;
      r_fill      <= '0;
      r_confirm   <= '0;
      r_stale     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_avg_valid <= 1'b0;

      if (bus.dist_valid)
        r_stale <= '0;
      else if (r_stale != STALE_MAX)
        r_stale <= r_stale + TW'(1);

      if (bus.dist_valid) begin
        if (r_state == S_FAULT) begin
          // Recovery sample restarts the window; deploy stays forced until re-qualified.
          r_buf[0] <= bus.distance_raw;
          for (int unsigned i = 1; i < DEPTH; i++) r_buf[i] <= '0;
          r_sum     <= SW'(bus.distance_raw);
          r_fill    <= FW'(1);
          r_confirm <= '0;
          r_fault   <= 1'b0;
          r_state   <= S_FILL;
        end else begin
          r_buf[0] <= bus.distance_raw;
          for (int unsigned i = 1; i < DEPTH; i++) r_buf[i] <= r_buf[i-1];
          r_sum <= w_sum_next;
          if (r_fill != FILL_FULL) r_fill <= r_fill + FW'(1);
          if (w_full_now) begin
            r_avg_valid <= 1'b1;
            r_avg       <= w_sum_next[SW-1:AVG_LOG2];
          end
          if ((r_state == S_FILL) && (r_fill == FILL_LAST))
            r_state <= r_deploy ? S_DEPLOYED : S_RETRACTED;
        end
      end

      if (w_decide) begin
        if (w_qual) begin
          if (r_confirm == CONF_LAST) begin
            r_confirm <= '0;
            r_deploy  <= (r_state == S_RETRACTED);
            r_state   <= (r_state == S_RETRACTED) ? S_DEPLOYED : S_RETRACTED;
          end else begin
            r_confirm <= r_confirm + 4'd1;
          end
        end else begin
          r_confirm <= '0;
        end
      end

      if (w_timeout) begin
        r_state  <= S_FAULT;
        r_fault  <= 1'b1;
        r_deploy <= 1'b1;
      end
    end
  end

  assign bus.deploy    = r_deploy;
  assign bus.dist_avg  = r_avg;
  assign bus.avg_valid = r_avg_valid;
  assign bus.fault     = r_fault;
  assign bus.state_dbg = r_state;

endmodule
